// File: rtl/rv_enc_pkg.sv
// Shared RV32I OP/OP-IMM encoding constants, used by both the ALU control decoder and the instruction encoder.
package rv_enc_pkg;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLL = 3'b100;
    localparam logic [2:0] ALU_SLT = 3'b101;

    localparam logic [6:0] OPC_OP      = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM  = 7'b0010011;
    localparam logic [6:0] FUNCT7_BASE = 7'b0000000;
    localparam logic [6:0] FUNCT7_ALT  = 7'b0100000;

    localparam logic [2:0] F3_ADD_SUB = 3'b000;
    localparam logic [2:0] F3_SLL     = 3'b001;
    localparam logic [2:0] F3_SLT     = 3'b010;
    localparam logic [2:0] F3_OR      = 3'b110;
    localparam logic [2:0] F3_AND     = 3'b111;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } enc_state_e;

    // SLLI needs no special case here: a legal SLLI already carries imm[11:5] = 0.
    function automatic logic [31:0] pack_word(
        input logic        is_imm,
        input logic [6:0]  funct7,
        input logic [2:0]  funct3,
        input logic [4:0]  rd,
        input logic [4:0]  rs1,
        input logic [4:0]  rs2,
        input logic [11:0] imm
    );
        if (is_imm)
            return {imm, rs1, funct3, rd, OPC_OP_IMM};
        else
            return {funct7, rs2, rs1, funct3, rd, OPC_OP};
    endfunction

endpackage

// File: rtl/alu_instr_encoder_if.sv
// Request and instruction-memory streaming bus of the instruction encoder.
interface alu_instr_encoder_if #(
    parameter int ADDR_W = 8
);
    logic              in_valid;
    logic              in_ready;
    logic [2:0]        in_alu_ctrl;
    logic              in_is_imm;
    logic [4:0]        in_rd;
    logic [4:0]        in_rs1;
    logic [4:0]        in_rs2;
    logic [11:0]       in_imm;
    logic              out_valid;
    logic              out_ready;
    logic [31:0]       out_instr;
    logic [ADDR_W-1:0] out_addr;

    modport master (
        output in_valid, in_alu_ctrl, in_is_imm, in_rd, in_rs1, in_rs2, in_imm, out_ready,
        input  in_ready, out_valid, out_instr, out_addr
    );

    modport slave (
        input  in_valid, in_alu_ctrl, in_is_imm, in_rd, in_rs1, in_rs2, in_imm, out_ready,
        output in_ready, out_valid, out_instr, out_addr
    );
endinterface

// File: rtl/alu_field_encoder.sv
// Maps an ALU control code to funct3/funct7 and flags combinations with no RV32I encoding.
module alu_field_encoder
    import rv_enc_pkg::*;
(
    input  logic [2:0] alu_ctrl,
    input  logic       is_imm,
    input  logic [6:0] imm_hi,
    output logic [2:0] funct3,
    output logic [6:0] funct7,
    output logic       legal
);

    always_comb begin
        funct3 = F3_ADD_SUB;
        funct7 = FUNCT7_BASE;
        legal  = 1'b1;
        case (alu_ctrl)
            ALU_ADD: funct3 = F3_ADD_SUB;
            ALU_SUB: begin
                funct7 = FUNCT7_ALT;
                legal  = !is_imm;
            end
            ALU_AND: funct3 = F3_AND;
            ALU_OR:  funct3 = F3_OR;
            // SLLI shares the immediate field with the shift amount; upper bits must be zero
            ALU_SLL: begin
                funct3 = F3_SLL;
                legal  = !is_imm || (imm_hi == 7'd0);
            end
            ALU_SLT: funct3 = F3_SLT;
            default: legal = 1'b0;
        endcase
    end

endmodule

// File: rtl/alu_instr_encoder.sv
// Encodes ALU requests into RV32I OP/OP-IMM words and streams them to instruction memory
// through a one-entry output register with an auto-incrementing word address.
module alu_instr_encoder
    import rv_enc_pkg::*;
#(
    parameter int                ADDR_W    = 8,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                clr,
    alu_instr_encoder_if.slave  bus,
    output logic                err,
    output logic                err_sticky,
    output logic [ADDR_W:0]     word_count
);

    enc_state_e        state;
    logic              out_valid_q;
    logic [31:0]       out_instr_q;
    logic [ADDR_W-1:0] out_addr_q;
    logic [ADDR_W-1:0] addr_cnt;

    logic [2:0]        funct3;
    logic [6:0]        funct7;
    logic              legal;
    logic              in_ready;
    logic              accept;
    logic              load;
    logic              deliver;
    logic [ADDR_W-1:0] next_addr;
    logic [31:0]       word;

    alu_field_encoder u_fields (
        .alu_ctrl (bus.in_alu_ctrl),
        .is_imm   (bus.in_is_imm),
        .imm_hi   (bus.in_imm[11:5]),
        .funct3   (funct3),
        .funct7   (funct7),
        .legal    (legal)
    );

    assign in_ready  = !clr && ((state == ST_EMPTY) || bus.out_ready);
    assign accept    = bus.in_valid && in_ready;
    assign load      = accept && legal;
    assign deliver   = out_valid_q && bus.out_ready && !clr;
    // a word loaded while the previous one leaves takes the following address
    assign next_addr = deliver ? addr_cnt + 1'b1 : addr_cnt;
    assign word      = pack_word(bus.in_is_imm, funct7, funct3, bus.in_rd,
                                 bus.in_rs1, bus.in_rs2, bus.in_imm);

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid_q;
    assign bus.out_instr = out_instr_q;
    assign bus.out_addr  = out_addr_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= ST_EMPTY;
            out_valid_q <= 1'b0;
            out_instr_q <= '0;
            out_addr_q  <= BASE_ADDR;
            addr_cnt    <= BASE_ADDR;
            err         <= 1'b0;
            err_sticky  <= 1'b0;
            word_count  <= '0;
        end else if (clr) begin
            state       <= ST_EMPTY;
            out_valid_q <= 1'b0;
            addr_cnt    <= BASE_ADDR;
            err         <= 1'b0;
            err_sticky  <= 1'b0;
            word_count  <= '0;
        end else begin
            err <= accept && !legal;
            if (accept && !legal)
                err_sticky <= 1'b1;

            if (deliver) begin
                addr_cnt <= addr_cnt + 1'b1;
                if (word_count != '1)
                    word_count <= word_count + 1'b1;
            end

            case (state)
                ST_EMPTY: begin
                    if (load) begin
                        out_instr_q <= word;
                        out_addr_q  <= next_addr;
                        out_valid_q <= 1'b1;
                        state       <= ST_FULL;
                    end
                end
                ST_FULL: begin
                    if (load) begin
                        out_instr_q <= word;
                        out_addr_q  <= next_addr;
                        out_valid_q <= 1'b1;
                    end else if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        state       <= ST_EMPTY;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_instr_encoder.sv
// Self-checking bench for alu_instr_encoder: directed scenarios plus a randomized run against a transaction-level model.
module tb_alu_instr_encoder;

    localparam int ADDR_W = 2;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              clr = 1'b0;
    logic              err;
    logic              err_sticky;
    logic [ADDR_W:0]   word_count;

    int vectors    = 0;
    int miscompares = 0;

    alu_instr_encoder_if #(.ADDR_W(ADDR_W)) bus ();

    alu_instr_encoder #(.ADDR_W(ADDR_W), .BASE_ADDR(2'd0)) dut (
        .clk        (clk),
        .rst        (rst),
        .clr        (clr),
        .bus        (bus),
        .err        (err),
        .err_sticky (err_sticky),
        .word_count (word_count)
    );

    always #5 clk = ~clk;

    // Reference encoding straight from the opcode tables, built with arithmetic.
    function automatic logic [31:0] ref_word(input int c, input int im, input int rd,
                                             input int rs1, input int rs2, input int imm);
        int f3, f7;
        f7 = 0;
        case (c)
            0: f3 = 0;
            1: begin f3 = 0; f7 = 32; end
            2: f3 = 7;
            3: f3 = 6;
            4: f3 = 1;
            default: f3 = 2;
        endcase
        if (im != 0)
            return 32'(imm * (1 << 20) + rs1 * (1 << 15) + f3 * (1 << 12) + rd * (1 << 7) + 19);
        else
            return 32'(f7 * (1 << 25) + rs2 * (1 << 20) + rs1 * (1 << 15) + f3 * (1 << 12) + rd * (1 << 7) + 51);
    endfunction

    function automatic bit ref_legal(input int c, input int im, input int imm);
        if (c > 5) return 1'b0;
        if (c == 1 && im != 0) return 1'b0;
        if (c == 4 && im != 0 && imm >= 32) return 1'b0;
        return 1'b1;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int c, input int im, input int rd, input int rs1,
                           input int rs2, input int imm);
        bus.in_alu_ctrl = 3'(c);
        bus.in_is_imm   = 1'(im);
        bus.in_rd       = 5'(rd);
        bus.in_rs1      = 5'(rs1);
        bus.in_rs2      = 5'(rs2);
        bus.in_imm      = 12'(imm);
        bus.in_valid    = 1'b1;
    endtask

    task automatic do_clr();
        bus.in_valid = 1'b0;
        clr = 1'b1;
        tick();
        clr = 1'b0;
    endtask

    task automatic test_reset();
        #3;
        vectors++; if (bus.out_valid !== 1'b0) begin miscompares++; $display("FAIL reset_out_valid got %0b want 0", bus.out_valid); end
        vectors++; if (bus.out_instr !== 32'h0) begin miscompares++; $display("FAIL reset_out_instr got %h want 0", bus.out_instr); end
        vectors++; if (bus.out_addr !== 2'd0) begin miscompares++; $display("FAIL reset_out_addr got %0d want 0", bus.out_addr); end
        vectors++; if (err !== 1'b0 || err_sticky !== 1'b0) begin miscompares++; $display("FAIL reset_err got %0b/%0b want 0/0", err, err_sticky); end
        vectors++; if (word_count !== 3'd0) begin miscompares++; $display("FAIL reset_word_count got %0d want 0", word_count); end
        vectors++; if (bus.in_ready !== 1'b1) begin miscompares++; $display("FAIL reset_in_ready got %0b want 1", bus.in_ready); end
        @(posedge clk);
        #1 rst = 1'b0;
        tick();
    endtask

    task automatic test_add();
        bus.out_ready = 1'b1;
        set_req(0, 0, 3, 1, 2, 0);
        tick();
        bus.in_valid = 1'b0;
        vectors++; if (bus.out_valid !== 1'b1) begin miscompares++; $display("FAIL add_valid got %0b want 1", bus.out_valid); end
        vectors++; if (bus.out_instr !== 32'h002081B3) begin miscompares++; $display("FAIL add_instr got %h want 002081b3", bus.out_instr); end
        vectors++; if (bus.out_addr !== 2'd0) begin miscompares++; $display("FAIL add_addr got %0d want 0", bus.out_addr); end
        tick();
        vectors++; if (bus.out_valid !== 1'b0) begin miscompares++; $display("FAIL add_valid_drop got %0b want 0", bus.out_valid); end
        vectors++; if (word_count !== 3'd1) begin miscompares++; $display("FAIL add_count got %0d want 1", word_count); end
    endtask

    task automatic test_back_to_back();
        do_clr();
        bus.out_ready = 1'b1;
        set_req(1, 0, 5, 6, 7, 0);
        tick();
        vectors++; if (bus.out_instr !== 32'h407302B3 || bus.out_addr !== 2'd0) begin miscompares++; $display("FAIL b2b_sub got %h@%0d want 407302b3@0", bus.out_instr, bus.out_addr); end
        set_req(2, 0, 10, 11, 12, 0);
        #1;
        vectors++; if (bus.in_ready !== 1'b1) begin miscompares++; $display("FAIL b2b_in_ready got %0b want 1", bus.in_ready); end
        tick();
        bus.in_valid = 1'b0;
        vectors++; if (bus.out_valid !== 1'b1 || bus.out_instr !== 32'h00C5F533 || bus.out_addr !== 2'd1) begin miscompares++; $display("FAIL b2b_and got v%0b %h@%0d want v1 00c5f533@1", bus.out_valid, bus.out_instr, bus.out_addr); end
        tick();
        vectors++; if (word_count !== 3'd2 || bus.out_valid !== 1'b0) begin miscompares++; $display("FAIL b2b_count got %0d v%0b want 2 v0", word_count, bus.out_valid); end
    endtask

    task automatic test_stall();
        do_clr();
        bus.out_ready = 1'b0;
        set_req(0, 1, 1, 0, 0, 12'hFFF);
        #1;
        vectors++; if (bus.in_ready !== 1'b1) begin miscompares++; $display("FAIL stall_empty_ready got %0b want 1", bus.in_ready); end
        tick();
        set_req(3, 1, 2, 3, 0, 12'h123);
        for (int i = 0; i < 3; i++) begin
            #1;
            vectors++; if (bus.out_valid !== 1'b1 || bus.out_instr !== 32'hFFF00093) begin miscompares++; $display("FAIL stall_hold%0d got v%0b %h want v1 fff00093", i, bus.out_valid, bus.out_instr); end
            vectors++; if (bus.in_ready !== 1'b0) begin miscompares++; $display("FAIL stall_in_ready%0d got %0b want 0", i, bus.in_ready); end
            tick();
        end
        bus.out_ready = 1'b1;
        #1;
        vectors++; if (bus.in_ready !== 1'b1) begin miscompares++; $display("FAIL stall_release_ready got %0b want 1", bus.in_ready); end
        tick();
        bus.in_valid = 1'b0;
        vectors++; if (bus.out_instr !== ref_word(3, 1, 2, 3, 0, 12'h123) || bus.out_addr !== 2'd1) begin miscompares++; $display("FAIL stall_second got %h@%0d want %h@1", bus.out_instr, bus.out_addr, ref_word(3, 1, 2, 3, 0, 12'h123)); end
        tick();
        vectors++; if (word_count !== 3'd2) begin miscompares++; $display("FAIL stall_count got %0d want 2", word_count); end
    endtask

    task automatic test_illegal();
        do_clr();
        bus.out_ready = 1'b1;
        set_req(7, 0, 1, 2, 3, 0);
        tick();
        vectors++; if (err !== 1'b1 || bus.out_valid !== 1'b0) begin miscompares++; $display("FAIL ill_ctrl7 got err%0b v%0b want err1 v0", err, bus.out_valid); end
        set_req(1, 1, 1, 2, 3, 5);
        tick();
        vectors++; if (err !== 1'b1 || err_sticky !== 1'b1 || bus.out_valid !== 1'b0) begin miscompares++; $display("FAIL ill_subi got err%0b st%0b v%0b want 1 1 0", err, err_sticky, bus.out_valid); end
        bus.in_valid = 1'b0;
        tick();
        vectors++; if (err !== 1'b0 || err_sticky !== 1'b1 || word_count !== 3'd0) begin miscompares++; $display("FAIL ill_after got err%0b st%0b cnt%0d want 0 1 0", err, err_sticky, word_count); end
        set_req(4, 1, 4, 5, 0, 12'h040);
        tick();
        vectors++; if (err !== 1'b1 || bus.out_valid !== 1'b0) begin miscompares++; $display("FAIL ill_slli got err%0b v%0b want 1 0", err, bus.out_valid); end
        set_req(4, 1, 4, 5, 0, 12'h01F);
        tick();
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b0;
        vectors++; if (bus.out_valid !== 1'b1 || bus.out_instr !== 32'h01F29213 || bus.out_addr !== 2'd0 || err !== 1'b0) begin miscompares++; $display("FAIL slli_legal got v%0b %h@%0d err%0b want v1 01f29213@0 err0", bus.out_valid, bus.out_instr, bus.out_addr, err); end
        tick();
        bus.out_ready = 1'b1;
        clr = 1'b1;
        #1;
        vectors++; if (bus.in_ready !== 1'b0) begin miscompares++; $display("FAIL clr_in_ready got %0b want 0", bus.in_ready); end
        tick();
        clr = 1'b0;
        vectors++; if (bus.out_valid !== 1'b0 || word_count !== 3'd0 || err_sticky !== 1'b0) begin miscompares++; $display("FAIL clr_discard got v%0b cnt%0d st%0b want 0 0 0", bus.out_valid, word_count, err_sticky); end
    endtask

    task automatic test_wrap_and_rst();
        do_clr();
        bus.out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            set_req(i % 6, 0, i + 1, i + 2, i + 3, 0);
            tick();
            vectors++; if (bus.out_valid !== 1'b1 || bus.out_addr !== 2'(i % 4)) begin miscompares++; $display("FAIL wrap%0d got v%0b @%0d want v1 @%0d", i, bus.out_valid, bus.out_addr, i % 4); end
        end
        bus.in_valid = 1'b0;
        vectors++; if (word_count !== 3'd4) begin miscompares++; $display("FAIL wrap_count got %0d want 4", word_count); end
        #2 rst = 1'b1;
        #1;
        vectors++; if (bus.out_valid !== 1'b0 || bus.out_addr !== 2'd0 || word_count !== 3'd0 || bus.out_instr !== 32'h0) begin miscompares++; $display("FAIL async_rst got v%0b @%0d cnt%0d %h want v0 @0 cnt0 0", bus.out_valid, bus.out_addr, word_count, bus.out_instr); end
        tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic test_random();
        bit m_full, m_sticky, exp_rdy, acc, leg, del, m_err;
        logic [31:0] m_word, w;
        int m_addr, nlegal, ndel, c, im, rd, rs1, rs2, imm;
        m_full = 0; m_sticky = 0; nlegal = 0; ndel = 0; m_word = '0; m_addr = 0;
        do_clr();
        for (int cyc = 0; cyc < 300; cyc++) begin
            c   = $urandom_range(0, 7);
            im  = $urandom_range(0, 1);
            rd  = $urandom_range(0, 31);
            rs1 = $urandom_range(0, 31);
            rs2 = $urandom_range(0, 31);
            imm = $urandom_range(0, 4095);
            if ($urandom_range(0, 1) == 1) imm = imm % 32;
            set_req(c, im, rd, rs1, rs2, imm);
            bus.in_valid  = ($urandom_range(0, 2) != 0);
            bus.out_ready = ($urandom_range(0, 3) != 0);
            #1;
            exp_rdy = !m_full || bus.out_ready;
            vectors++; if (bus.in_ready !== exp_rdy) begin miscompares++; $display("FAIL rnd_in_ready cyc%0d got %0b want %0b", cyc, bus.in_ready, exp_rdy); end
            acc = bus.in_valid && exp_rdy;
            leg = ref_legal(c, im, imm);
            del = m_full && bus.out_ready;
            w   = ref_word(c, im, rd, rs1, rs2, imm);
            tick();
            if (del) ndel++;
            if (acc && leg) begin
                m_word = w;
                m_addr = nlegal % 4;
                nlegal++;
                m_full = 1;
            end else if (del) begin
                m_full = 0;
            end
            m_err = acc && !leg;
            m_sticky = m_sticky | m_err;
            vectors++; if (bus.out_valid !== m_full) begin miscompares++; $display("FAIL rnd_valid cyc%0d got %0b want %0b", cyc, bus.out_valid, m_full); end
            if (m_full) begin
                vectors++; if (bus.out_instr !== m_word || bus.out_addr !== 2'(m_addr)) begin miscompares++; $display("FAIL rnd_word cyc%0d got %h@%0d want %h@%0d", cyc, bus.out_instr, bus.out_addr, m_word, m_addr); end
            end
            vectors++; if (err !== m_err || err_sticky !== m_sticky) begin miscompares++; $display("FAIL rnd_err cyc%0d got %0b/%0b want %0b/%0b", cyc, err, err_sticky, m_err, m_sticky); end
            vectors++; if (word_count !== 3'(ndel > 7 ? 7 : ndel)) begin miscompares++; $display("FAIL rnd_count cyc%0d got %0d want %0d", cyc, word_count, (ndel > 7 ? 7 : ndel)); end
        end
        bus.in_valid = 1'b0;
    endtask

    initial begin
        bus.in_valid    = 1'b0;
        bus.in_alu_ctrl = 3'd0;
        bus.in_is_imm   = 1'b0;
        bus.in_rd       = 5'd0;
        bus.in_rs1      = 5'd0;
        bus.in_rs2      = 5'd0;
        bus.in_imm      = 12'd0;
        bus.out_ready   = 1'b0;
        test_reset();
        test_add();
        test_back_to_back();
        test_stall();
        test_illegal();
        test_wrap_and_rst();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/alu_instr_encoder.md
Name: alu_instr_encoder

Overview:
- Inverse of the ALU control decode path. Takes an ALU operation code (same 3-bit ALUControl encoding the core's decoder produces) plus register/immediate fields, and encodes a legal RV32I OP or OP-IMM instruction word.
- Streams each word to instruction memory through a valid/ready output stage, with an auto-incrementing word address.
- Used by the test/program loader to build instruction streams for the processing element without an external assembler.

Parameters:
- ADDR_W, 8, width of the instruction-memory word address.
- BASE_ADDR, 0, word address loaded into the address counter on reset and on clr.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  reset, asynchronous, active-high.
- clr  input  1  synchronous: reset address counter to BASE_ADDR, drop any held output, clear err_sticky.
- in_valid  input  1  request valid.
- in_ready  output  1  request accepted when in_valid and in_ready are both high.
- in_alu_ctrl  input  3  000 ADD, 001 SUB, 010 AND, 011 OR, 100 SLL, 101 SLT.
- in_is_imm  input  1  0 = R-type (opcode 0110011), 1 = I-type (opcode 0010011).
- in_rd  input  5  destination register.
- in_rs1  input  5  source register 1.
- in_rs2  input  5  source register 2 (ignored when in_is_imm = 1).
- in_imm  input  12  I-type immediate (ignored when in_is_imm = 0).
- out_valid  output  1  encoded word valid.
- out_ready  input  1  downstream (imem write port) ready.
- out_instr  output  32  encoded instruction.
- out_addr  output  ADDR_W  word address for out_instr.
- err  output  1  one-cycle pulse: the accepted request was illegal.
- err_sticky  output  1  set by any err; cleared by rst or clr.
- word_count  output  ADDR_W+1  number of words delivered since rst or clr (saturates at all-ones).

Behaviour:
- Reset (async, rst = 1): out_valid = 0, out_instr = 0, out_addr = BASE_ADDR, err = 0, err_sticky = 0, word_count = 0, internal state = EMPTY.
- Encoding map (alu_ctrl -> funct3 / funct7):
  - ADD -> 000 / 0000000
  - SUB -> 000 / 0100000
  - AND -> 111 / 0000000
  - OR -> 110 / 0000000
  - SLL -> 001 / 0000000
  - SLT -> 010 / 0000000
- R-type word: {funct7, rs2, rs1, funct3, rd, 0110011}.
- I-type word: {imm[11:0], rs1, funct3, rd, 0010011}.
- I-type SLL (SLLI): word uses imm[11:5] = 0000000 and shamt = imm[4:0].
- Illegal requests:
  - alu_ctrl 110 or 111,
  - SUB with is_imm = 1,
  - SLL with is_imm = 1 and imm[11:5] != 0.
  - On acceptance of an illegal request: err pulses 1 in the following cycle, err_sticky sets, nothing is emitted, and the address does not advance.
- Output stage is a single register with a 2-state FSM:
  - EMPTY (out_valid = 0). On a legal accept: load out_instr and out_addr, go to FULL.
  - FULL (out_valid = 1). If out_ready = 1 and no legal accept: go to EMPTY. If out_ready = 1 and a legal accept in the same cycle: reload and stay FULL (back-to-back, one word per cycle).
- Latency: accept in cycle N -> out_valid in cycle N+1.
- in_ready = (state == EMPTY) || out_ready. This is combinational from out_ready; there is no combinational path from in_valid to in_ready.
- out_instr and out_addr stay stable while out_valid = 1 and out_ready = 0.
- Address counter advances by 1 on each delivered word (out_valid && out_ready) and wraps modulo 2^ADDR_W. out_addr latches the counter value at load time. word_count increments on each delivery.
- clr has priority over all handshakes in its cycle: state goes to EMPTY and any held word is discarded, not delivered. in_ready is 0 during clr.
- rst asserted mid-transfer: held word is lost, all outputs return to reset values immediately (asynchronously).

Decomposition:
- Shared package rv_enc_pkg:
  - ALUControl localparams (ALU_ADD … ALU_SLT),
  - OPC_OP = 7'b0110011, OPC_OP_IMM = 7'b0010011,
  - FUNCT7_ALT = 7'b0100000,
  - funct3 constants.
  - The same constants serve the existing decoder.
- One combinational sub-module, alu_field_encoder: maps {alu_ctrl, is_imm, imm} to {funct3, funct7, legal}. The top level holds the FSM, the output register and the counters.

Test Plan:
- ADD x3,x1,x2 (R), out_ready = 1, after rst -> out_instr 0x002081B3, out_addr 0, out_valid for 1 cycle.
- SUB x5,x6,x7 then AND x10,x11,x12 back-to-back, out_ready = 1 -> 0x407302B3 @addr 0, then 0x00C5F533 @addr 1; in_ready stays 1; word_count = 2.
- ADDI x1,x0,-1 (imm 0xFFF) with out_ready held 0 for 3 cycles -> out_instr 0xFFF00093 stable; in_ready = 0 until out_ready = 1; a second request is held off.
- Illegal requests: alu_ctrl 111, then SUB with is_imm = 1 -> err pulses twice, err_sticky = 1, no out_valid, address unchanged. Then clr -> err_sticky = 0.
- ADDR_W = 2: deliver 5 legal words -> addresses 0, 1, 2, 3, 0 (wrap). Then rst asserted while FULL -> out_valid drops immediately and out_addr = BASE_ADDR.
